// File: rtl/quick_spi.sv
// SPI mode-0 master: shifts one byte out on mosi, MSB first, while capturing one byte from miso.
// The SCK period is 2^CLK_DIV system clocks, and sck is the MSB of the divider counter.
module quick_spi #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       miso,
  output logic       mosi,
  output logic       sck,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       new_data
);

  typedef enum logic {
    IDLE,
    TRANSFER
  } state_t;

  localparam logic [CLK_DIV-1:0] DIV_MAX  = '1;
  localparam logic [CLK_DIV-1:0] DIV_HALF = DIV_MAX >> 1;

  state_t             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [CLK_DIV-1:0] div_q, div_d;
  logic [2:0]         bit_q, bit_d;
  logic               mosi_q, mosi_d;
  logic [7:0]         dout_q, dout_d;
  logic               nd_q, nd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      mosi_q  <= 1'b0;
      dout_q  <= '0;
      nd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      mosi_q  <= mosi_d;
      dout_q  <= dout_d;
      nd_q    <= nd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    bit_d   = bit_q;
    mosi_d  = mosi_q;
    dout_d  = dout_q;
    nd_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TRANSFER;
          shift_d = data_in;
          mosi_d  = data_in[7];
          div_d   = '0;
          bit_d   = '0;
        end
      end
      TRANSFER: begin
        div_d = div_q + 1'b1;
        // The sck rising edge samples miso, and the falling edge presents the next bit.
        if (div_q == DIV_HALF) begin
          shift_d = {shift_q[6:0], miso};
        end
        if (div_q == DIV_MAX) begin
          mosi_d = shift_q[7];
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = IDLE;
            dout_d  = shift_q;
            nd_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == TRANSFER);
  assign sck      = busy & div_q[CLK_DIV-1];
  assign mosi     = mosi_q;
  assign data_out = dout_q;
  assign new_data = nd_q;

endmodule

// File: tb/tb_quick_spi.sv
// Directed bench for quick_spi with CLK_DIV=2: loopback, constant miso, back-to-back, reset abort, ignored start.
module tb_quick_spi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       miso;
  logic       mosi;
  logic       sck;
  logic [7:0] data_out;
  logic       busy;
  logic       new_data;

  logic       loop_en = 1'b0;
  logic       miso_drv = 1'b0;

  int vectors = 0;
  int fails = 0;

  assign miso = loop_en ? mosi : miso_drv;

  quick_spi #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .miso(miso),
    .mosi(mosi), .sck(sck), .data_out(data_out), .busy(busy), .new_data(new_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer with a one-cycle start pulse, then counts busy cycles until idle (bounded).
  task automatic pulse_and_run(input logic [7:0] d, output int nbusy);
    data_in = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      nbusy++;
      tick();
    end
  endtask

  initial begin
    int nb;
    int rises;
    int bad_sck, bad_mosi, bad_misc;
    logic prev_sck;
    logic [7:0] pat;

    // reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_new_data", 32'(new_data), 32'd0);

    // loopback 0x6C: per-cycle waveform of sck/mosi/busy
    loop_en = 1'b1;
    pat = 8'h6C;
    data_in = pat;
    start = 1'b1;
    tick();
    start = 1'b0;
    rises = 0; bad_sck = 0; bad_mosi = 0; bad_misc = 0;
    prev_sck = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (sck !== ((k % 4) >= 2)) bad_sck++;
      if (mosi !== pat[7 - k / 4]) bad_mosi++;
      if (busy !== 1'b1 || new_data !== 1'b0) bad_misc++;
      if (sck === 1'b1 && prev_sck === 1'b0) rises++;
      prev_sck = sck;
      tick();
    end
    check("lb_sck_pattern_errs", 32'(bad_sck), 32'd0);
    check("lb_mosi_seq_errs", 32'(bad_mosi), 32'd0);
    check("lb_busy_nd_errs", 32'(bad_misc), 32'd0);
    check("lb_sck_rises", 32'(rises), 32'd8);
    check("lb_end_busy", 32'(busy), 32'd0);
    check("lb_end_sck", 32'(sck), 32'd0);
    check("lb_new_data", 32'(new_data), 32'd1);
    check("lb_data_out", 32'(data_out), 32'h6C);
    tick();
    check("lb_nd_drop", 32'(new_data), 32'd0);
    check("lb_data_hold", 32'(data_out), 32'h6C);

    // constant miso 1, then constant 0
    loop_en = 1'b0;
    miso_drv = 1'b1;
    pulse_and_run(8'h00, nb);
    check("ones_len", 32'(nb), 32'd32);
    check("ones_data", 32'(data_out), 32'hFF);
    check("ones_nd", 32'(new_data), 32'd1);
    miso_drv = 1'b0;
    pulse_and_run(8'hFF, nb);
    check("zeros_len", 32'(nb), 32'd32);
    check("zeros_data", 32'(data_out), 32'h00);

    // start held high: back-to-back with a single idle cycle
    loop_en = 1'b1;
    data_in = 8'hA5;
    start = 1'b1;
    tick();
    nb = 0;
    for (int k = 0; k < 32; k++) begin
      if (busy === 1'b1) nb++;
      tick();
    end
    check("b2b_first_len", 32'(nb), 32'd32);
    check("b2b_gap_busy", 32'(busy), 32'd0);
    check("b2b_gap_nd", 32'(new_data), 32'd1);
    check("b2b_first_data", 32'(data_out), 32'hA5);
    tick();
    check("b2b_restart_busy", 32'(busy), 32'd1);
    check("b2b_restart_nd", 32'(new_data), 32'd0);
    start = 1'b0;
    nb = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!busy) break;
      nb++;
    end
    check("b2b_second_len", 32'(nb), 32'd32);
    check("b2b_second_data", 32'(data_out), 32'hA5);
    check("b2b_second_nd", 32'(new_data), 32'd1);

    // reset at cycle 10 of a transfer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data_in = 8'h6C;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_nd", 32'(new_data), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    tick();
    check("abort_after_nd", 32'(new_data), 32'd0);
    check("abort_after_busy", 32'(busy), 32'd0);

    // start pulsed at cycle 5 with different data is ignored
    loop_en = 1'b1;
    data_in = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      nb++;
      if (k == 5) begin
        start = 1'b1;
        data_in = 8'hFF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("ign_len", 32'(nb), 32'd32);
    check("ign_data", 32'(data_out), 32'h3C);
    check("ign_nd", 32'(new_data), 32'd1);
    tick();
    check("ign_stays_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quick_spi.md
QUICK_SPI -- requirements
Module: quick_spi

Interface
REQ-001 Parameter CLK_DIV, default 2, log2 of SCK period in clk cycles; legal range 1..8; SCK period = 2^CLK_DIV clk cycles.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  transfer request, sampled in IDLE only.
REQ-005 data_in  input  8  byte to transmit, MSB first, latched on accepted start.
REQ-006 miso  input  1  serial data from slave.
REQ-007 mosi  output  1  serial data to slave, registered.
REQ-008 sck  output  1  serial clock, SPI mode 0 (idle low, sample on rising edge, shift on falling edge).
REQ-009 data_out  output  8  last received byte, held until next completion.
REQ-010 busy  output  1  high while state is TRANSFER.
REQ-011 new_data  output  1  one-cycle pulse, data_out just updated.

Function
REQ-012 Two states, IDLE and TRANSFER; busy SHALL equal (state == TRANSFER) with no extra latency.
REQ-013 Internal registers: 8-bit shift register, CLK_DIV-bit divider counter div, 3-bit bit counter.
REQ-014 IDLE with start=1 at an edge: state<=TRANSFER, shift<=data_in, mosi<=data_in[7], div<=0, bit counter<=0.
REQ-015 IDLE with start=0: no change; sck=0; mosi holds its last value.
REQ-016 TRANSFER: div increments by 1 every clk, wrapping modulo 2^CLK_DIV.
REQ-017 sck SHALL equal the MSB of div in TRANSFER and 0 in IDLE: low for the first half of each bit period, high for the second half.
REQ-018 At the edge where div == 2^(CLK_DIV-1)-1 (sck rising), shift<={shift[6:0], miso}.
REQ-019 At the edge where div == all ones (sck falling), mosi<=shift[7] and bit counter increments.
REQ-020 At the edge where div == all ones and bit counter == 7: state<=IDLE, data_out<=shift, new_data<=1.
REQ-021 new_data SHALL be 0 in every other cycle; it is asserted in the first IDLE cycle after a transfer.
REQ-022 A transfer SHALL last exactly 8*2^CLK_DIV cycles with busy=1 (32 for CLK_DIV=2).
REQ-023 start while busy=1 SHALL be ignored; data_in changes during TRANSFER SHALL not affect the transfer.
REQ-024 start held high continuously: the next transfer is accepted in the first IDLE cycle, giving busy=0 for exactly one cycle between transfers.
REQ-025 Received bits SHALL be MSB first: the first sampled miso bit ends in data_out[7].

Reset
REQ-026 rst=1 at an edge SHALL force state=IDLE, div=0, bit counter=0, shift=0, mosi=0, data_out=0, new_data=0; sck=0 and busy=0 follow combinationally.
REQ-027 rst has priority over start and over an in-progress transfer; a mid-transfer reset SHALL abort without a new_data pulse.

Verification
REQ-028 CLK_DIV=2, miso tied to mosi, data_in=0x6C, one-cycle start -> busy high 32 cycles, new_data single pulse, data_out=0x6C.
REQ-029 CLK_DIV=2, data_in=0x6C -> mosi sequence 0,1,1,0,1,1,0,0, each bit stable for 4 clks; sck pattern 0,0,1,1 per bit; 8 sck rising edges.
REQ-030 miso constant 1 then constant 0 transfers -> data_out=0xFF then 0x00.
REQ-031 start held high with data_in=0xA5 -> back-to-back transfers, busy low exactly 1 cycle between, new_data in that cycle.
REQ-032 rst asserted at cycle 10 of a transfer -> next cycle busy=0, sck=0, mosi=0, no new_data, data_out unchanged at 0.
REQ-033 Pulse start again at cycle 5 of a busy transfer with different data_in -> ignored, transfer length and data unchanged.
